// File: rtl/bus_monitor_axil_regs.sv
// AXI4-Lite slave register file for the bus monitor IP.
// NUM_REGS 32-bit read/write configuration registers on the S00_AXI port.
// The write and read channels each run an independent handshake FSM, and
// both fully support backpressure on B and R. reg_out exposes every register
// to the monitor core as one flat vector.
module bus_monitor_axil_regs #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_REGS   = 4
) (
   input  logic                           ACLK,
   input  logic                           ARESETN,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                     S_AXI_AWPROT,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                     S_AXI_ARPROT,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

   localparam int IDX_W  = ADDR_WIDTH - 2;
   localparam int STRB_W = DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // WR_INIT / RD_INIT keep every ready low until the first edge after reset.
   typedef enum logic [2:0] {
      WR_INIT    = 3'd0,
      WR_IDLE    = 3'd1,
      WR_HAVE_AW = 3'd2,
      WR_HAVE_W  = 3'd3,
      WR_RESP    = 3'd4
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_INIT = 2'd0,
      RD_IDLE = 2'd1,
      RD_RESP = 2'd2
   } rd_state_t;

   // Byte-lane merge: lanes with their strobe set take the new data.
   function automatic logic [DATA_WIDTH-1:0] strb_merge(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] new_v,
      input logic [STRB_W-1:0]     strb
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_v;
      for (int b = 0; b < STRB_W; b++) begin
         res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   // The register index is in range when it selects an implemented register.
   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return (32'(idx) < 32'(NUM_REGS));
   endfunction

   // ------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------
   wr_state_t             wr_state_r;
   wr_state_t             wr_state_nx_s;
   logic                  awready_r;
   logic                  wready_r;
   logic                  bvalid_r;
   logic [1:0]            bresp_r;
   logic                  awready_nx_s;
   logic                  wready_nx_s;
   logic                  bvalid_nx_s;

   logic                  aw_hs_s;
   logic                  w_hs_s;
   logic                  commit_s;
   logic [IDX_W-1:0]      aw_idx_in_s;
   logic [IDX_W-1:0]      cm_idx_s;
   logic [DATA_WIDTH-1:0] cm_data_s;
   logic [STRB_W-1:0]     cm_strb_s;
   logic                  cm_ok_s;

   logic [IDX_W-1:0]      aw_idx_r;
   logic [DATA_WIDTH-1:0] w_data_r;
   logic [STRB_W-1:0]     w_strb_r;

   logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

   rd_state_t             rd_state_r;
   rd_state_t             rd_state_nx_s;
   logic                  arready_r;
   logic                  rvalid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;
   logic                  arready_nx_s;
   logic                  rvalid_nx_s;
   logic                  ar_hs_s;
   logic [IDX_W-1:0]      ar_idx_s;
   logic                  rd_ok_s;
   logic [DATA_WIDTH-1:0] rd_val_s;

   // Protection bits and the byte offset inside a word have no effect.
   logic                  unused_s;
   assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   assign aw_hs_s     = S_AXI_AWVALID & awready_r;
   assign w_hs_s      = S_AXI_WVALID & wready_r;
   assign aw_idx_in_s = S_AXI_AWADDR[ADDR_WIDTH-1:2];

   // Write FSM state register, plus the registered handshake outputs.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_r <= WR_INIT;
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         bvalid_r   <= 1'b0;
      end else begin
         wr_state_r <= wr_state_nx_s;
         awready_r  <= awready_nx_s;
         wready_r   <= wready_nx_s;
         bvalid_r   <= bvalid_nx_s;
      end
   end

   // Write FSM next state: collect AW and W in either order, then wait for B.
   always_comb begin
      wr_state_nx_s = wr_state_r;
      case (wr_state_r)
         WR_INIT: begin
            wr_state_nx_s = WR_IDLE;
         end
         WR_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               wr_state_nx_s = WR_RESP;
            end else if (aw_hs_s) begin
               wr_state_nx_s = WR_HAVE_AW;
            end else if (w_hs_s) begin
               wr_state_nx_s = WR_HAVE_W;
            end else begin
               wr_state_nx_s = WR_IDLE;
            end
         end
         WR_HAVE_AW: begin
            if (w_hs_s) begin
               wr_state_nx_s = WR_RESP;
            end else begin
               wr_state_nx_s = WR_HAVE_AW;
            end
         end
         WR_HAVE_W: begin
            if (aw_hs_s) begin
               wr_state_nx_s = WR_RESP;
            end else begin
               wr_state_nx_s = WR_HAVE_W;
            end
         end
         WR_RESP: begin
            if (S_AXI_BREADY) begin
               wr_state_nx_s = WR_IDLE;
            end else begin
               wr_state_nx_s = WR_RESP;
            end
         end
         default: begin
            wr_state_nx_s = WR_INIT;
         end
      endcase
   end

   // Write FSM outputs: decoded from the next state so they register cleanly.
   always_comb begin
      awready_nx_s = 1'b0;
      wready_nx_s  = 1'b0;
      bvalid_nx_s  = 1'b0;
      case (wr_state_nx_s)
         WR_IDLE: begin
            awready_nx_s = 1'b1;
            wready_nx_s  = 1'b1;
         end
         WR_HAVE_AW: begin
            wready_nx_s  = 1'b1;
         end
         WR_HAVE_W: begin
            awready_nx_s = 1'b1;
         end
         WR_RESP: begin
            bvalid_nx_s  = 1'b1;
         end
         default: begin
            awready_nx_s = 1'b0;
            wready_nx_s  = 1'b0;
            bvalid_nx_s  = 1'b0;
         end
      endcase
   end

   // Commit decode: the handshake that completes the AW/W pair commits,
   // taking whichever half was buffered from the holding registers.
   always_comb begin
      commit_s = 1'b0;
      case (wr_state_r)
         WR_IDLE:    commit_s = aw_hs_s & w_hs_s;
         WR_HAVE_AW: commit_s = w_hs_s;
         WR_HAVE_W:  commit_s = aw_hs_s;
         default:    commit_s = 1'b0;
      endcase
      cm_idx_s  = (wr_state_r == WR_HAVE_AW) ? aw_idx_r : aw_idx_in_s;
      cm_data_s = (wr_state_r == WR_HAVE_W)  ? w_data_r : S_AXI_WDATA;
      cm_strb_s = (wr_state_r == WR_HAVE_W)  ? w_strb_r : S_AXI_WSTRB;
      cm_ok_s   = idx_in_range(cm_idx_s);
   end

   // AW/W holding registers: load on handshake, clear when the pair commits.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_idx_r <= '0;
         w_data_r <= '0;
         w_strb_r <= '0;
      end else if (commit_s) begin
         aw_idx_r <= '0;
         w_data_r <= '0;
         w_strb_r <= '0;
      end else begin
         if (aw_hs_s) begin
            aw_idx_r <= aw_idx_in_s;
         end
         if (w_hs_s) begin
            w_data_r <= S_AXI_WDATA;
            w_strb_r <= S_AXI_WSTRB;
         end
      end
   end

   // Write response code, captured at commit and held through the B phase.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         bresp_r <= RESP_OKAY;
      end else if (commit_s) begin
         bresp_r <= cm_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
         bresp_r <= bresp_r;
      end
   end

   // Register file: a strobed byte merge into the addressed register on commit.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (commit_s && cm_ok_s && (32'(cm_idx_s) == 32'(k))) begin
               regs_r[k] <= strb_merge(regs_r[k], cm_data_s, cm_strb_s);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   assign ar_hs_s  = S_AXI_ARVALID & arready_r;
   assign ar_idx_s = S_AXI_ARADDR[ADDR_WIDTH-1:2];
   assign rd_ok_s  = idx_in_range(ar_idx_s);

   // Read FSM state register, plus the registered handshake outputs.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state_r <= RD_INIT;
         arready_r  <= 1'b0;
         rvalid_r   <= 1'b0;
      end else begin
         rd_state_r <= rd_state_nx_s;
         arready_r  <= arready_nx_s;
         rvalid_r   <= rvalid_nx_s;
      end
   end

   // Read FSM next state: accept an AR, then hold R until RREADY.
   always_comb begin
      rd_state_nx_s = rd_state_r;
      case (rd_state_r)
         RD_INIT: begin
            rd_state_nx_s = RD_IDLE;
         end
         RD_IDLE: begin
            if (ar_hs_s) begin
               rd_state_nx_s = RD_RESP;
            end else begin
               rd_state_nx_s = RD_IDLE;
            end
         end
         RD_RESP: begin
            if (S_AXI_RREADY) begin
               rd_state_nx_s = RD_IDLE;
            end else begin
               rd_state_nx_s = RD_RESP;
            end
         end
         default: begin
            rd_state_nx_s = RD_INIT;
         end
      endcase
   end

   // Read FSM outputs, decoded from the next state.
   always_comb begin
      arready_nx_s = 1'b0;
      rvalid_nx_s  = 1'b0;
      case (rd_state_nx_s)
         RD_IDLE: arready_nx_s = 1'b1;
         RD_RESP: rvalid_nx_s  = 1'b1;
         default: begin
            arready_nx_s = 1'b0;
            rvalid_nx_s  = 1'b0;
         end
      endcase
   end

   // Read mux: the current (pre-write) value of the addressed register.
   always_comb begin
      rd_val_s = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         rd_val_s = (32'(ar_idx_s) == 32'(k)) ? regs_r[k] : rd_val_s;
      end
   end

   // Read data/response, loaded on the AR handshake and held until R completes.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rdata_r <= '0;
         rresp_r <= RESP_OKAY;
      end else if (ar_hs_s) begin
         rdata_r <= rd_ok_s ? rd_val_s : '0;
         rresp_r <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
         rdata_r <= rdata_r;
         rresp_r <= rresp_r;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign S_AXI_AWREADY = awready_r;
   assign S_AXI_WREADY  = wready_r;
   assign S_AXI_BVALID  = bvalid_r;
   assign S_AXI_BRESP   = bresp_r;
   assign S_AXI_ARREADY = arready_r;
   assign S_AXI_RVALID  = rvalid_r;
   assign S_AXI_RDATA   = rdata_r;
   assign S_AXI_RRESP   = rresp_r;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
   end

endmodule

// File: tb/tb_bus_monitor_axil_regs.sv
// Self-checking bench for bus_monitor_axil_regs: directed scenarios plus
// randomized AXI-Lite traffic, checked against a transaction-level model.
module tb_bus_monitor_axil_regs;

   localparam int AW = 6;
   localparam int NR = 4;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [AW-1:0] awaddr = '0;
   logic [2:0]    awprot = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [31:0]   wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          wvalid = 1'b0;
   logic          wready;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready = 1'b0;
   logic [AW-1:0] araddr = '0;
   logic [2:0]    arprot = '0;
   logic          arvalid = 1'b0;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready = 1'b0;
   logic [NR*32-1:0] reg_out;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: the architectural register contents.
   logic [31:0] m_regs [NR];

   bus_monitor_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .ACLK(aclk), .ARESETN(aresetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
      .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
      .S_AXI_RREADY(rready),
      .reg_out(reg_out)
   );

   always #5 aclk = ~aclk;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model_flat();
      logic [127:0] f;
      for (int k = 0; k < NR; k++) f[32*k +: 32] = m_regs[k];
      return f;
   endfunction

   function automatic bit model_ok(input logic [AW-1:0] addr);
      return (int'(addr) / 4) < NR;
   endfunction

   // Apply a write to the model: strobed bytes overwrite, others are kept.
   function automatic logic [1:0] model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int idx;
      idx = int'(addr) / 4;
      if (idx >= NR) return 2'b10;
      for (int b = 0; b < 4; b++)
         if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
      return 2'b00;
   endfunction

   function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
      return model_ok(addr) ? m_regs[int'(addr) / 4] : 32'h0;
   endfunction

   // One write; AW and W each start after their own delay, B held off b_dly cycles.
   // Entered and left just after a rising edge.
   task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int cyc = 0;
      logic [1:0] exp_resp;
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         @(negedge aclk);
         check_eq("wr_awready", awready, !aw_done);
         check_eq("wr_wready", wready, !w_done);
         check_eq("wr_bvalid_early", bvalid, 0);
         check_eq("wr_no_partial", reg_out, model_flat());
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(posedge aclk); #1;
         if (aw_fire) aw_done = 1;
         if (w_fire) w_done = 1;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(aw_done && w_done)) check_eq("wr_hs_timeout", 0, 1);
      exp_resp = model_write(addr, data, strb);
      for (int i = 0; i < b_dly; i++) begin
         @(negedge aclk);
         check_eq("b_hold_valid", bvalid, 1);
         check_eq("b_hold_resp", bresp, exp_resp);
         check_eq("b_hold_awready", awready, 0);
         check_eq("b_hold_wready", wready, 0);
         check_eq("b_hold_regout", reg_out, model_flat());
         @(posedge aclk); #1;
      end
      bready = 1'b1;
      @(negedge aclk);
      check_eq("bvalid", bvalid, 1);
      check_eq("bresp", bresp, exp_resp);
      check_eq("regout_after_wr", reg_out, model_flat());
      @(posedge aclk); #1;
      bready = 1'b0;
      @(negedge aclk);
      check_eq("bvalid_clear", bvalid, 0);
      check_eq("awready_back", awready, 1);
      check_eq("wready_back", wready, 1);
      @(posedge aclk); #1;
   endtask

   // One read with R held off r_dly cycles; returns the observed data.
   task automatic do_read(input logic [AW-1:0] addr, input int r_dly, output logic [31:0] got);
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      exp_data = model_read(addr);
      exp_resp = model_ok(addr) ? 2'b00 : 2'b10;
      araddr = addr; arvalid = 1'b1;
      @(negedge aclk);
      check_eq("arready", arready, 1);
      check_eq("rvalid_early", rvalid, 0);
      @(posedge aclk); #1;
      arvalid = 1'b0;
      for (int i = 0; i < r_dly; i++) begin
         @(negedge aclk);
         check_eq("r_hold_valid", rvalid, 1);
         check_eq("r_hold_data", rdata, exp_data);
         check_eq("r_hold_resp", rresp, exp_resp);
         check_eq("r_hold_arready", arready, 0);
         @(posedge aclk); #1;
      end
      rready = 1'b1;
      @(negedge aclk);
      check_eq("rvalid", rvalid, 1);
      check_eq("rdata", rdata, exp_data);
      check_eq("rresp", rresp, exp_resp);
      got = rdata;
      @(posedge aclk); #1;
      rready = 1'b0;
      @(negedge aclk);
      check_eq("rvalid_clear", rvalid, 0);
      check_eq("arready_back", arready, 1);
      @(posedge aclk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_awready"}, awready, 0);
      check_eq({tag, "_wready"}, wready, 0);
      check_eq({tag, "_arready"}, arready, 0);
      check_eq({tag, "_bvalid"}, bvalid, 0);
      check_eq({tag, "_rvalid"}, rvalid, 0);
      check_eq({tag, "_bresp"}, bresp, 0);
      check_eq({tag, "_rresp"}, rresp, 0);
      check_eq({tag, "_rdata"}, rdata, 0);
      check_eq({tag, "_regout"}, reg_out, 0);
   endtask

   task automatic do_reset_release();
      aresetn = 1'b1;
      @(negedge aclk);
      check_eq("rst_rel_awready", awready, 0);
      check_eq("rst_rel_arready", arready, 0);
      @(posedge aclk); #1;
      @(negedge aclk);
      check_eq("rdy_awready", awready, 1);
      check_eq("rdy_wready", wready, 1);
      check_eq("rdy_arready", arready, 1);
      @(posedge aclk); #1;
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] old_v;
      for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;

      // Reset state
      #1;
      check_all_zero("reset");
      repeat (2) @(posedge aclk);
      #1;
      do_reset_release();

      // Basic writes and read-back
      for (int k = 0; k < NR; k++) do_write(AW'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
      for (int k = 0; k < NR; k++) do_read(AW'(4 * k), 0, got);
      check_eq("regout_const", reg_out, 128'h00000004_00000003_00000002_00000001);

      // W three cycles ahead of AW
      do_write(6'h04, 32'hDEADBEEF, 4'hF, 3, 0, 0);
      check_eq("reg1_deadbeef", reg_out[63:32], 32'hDEADBEEF);
      // AW ahead of W
      do_write(6'h09, 32'h0BADF00D, 4'hF, 0, 2, 1);

      // Partial strobe merge
      do_write(6'h0C, 32'h11223344, 4'hF, 0, 0, 0);
      do_write(6'h0C, 32'hAABBCCDD, 4'b0101, 1, 0, 0);
      do_read(6'h0C, 0, got);
      check_eq("strb_merge_const", got, 32'h11BB33DD);

      // Out-of-range access
      do_write(6'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      do_read(6'h10, 0, got);

      // Backpressure on B and R
      do_write(6'h00, 32'hCAFEF00D, 4'hF, 0, 0, 5);
      do_read(6'h00, 5, got);

      // Same-edge read and write of one register
      old_v = m_regs[2];
      awaddr = 6'h08; wdata = 32'h5A5A1234; wstrb = 4'hF; araddr = 6'h08;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(negedge aclk);
      check_eq("rw_readies", {awready, wready, arready}, 3'b111);
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      void'(model_write(6'h08, 32'h5A5A1234, 4'hF));
      @(negedge aclk);
      check_eq("rw_rdata_old", rdata, old_v);
      check_eq("rw_bvalid", bvalid, 1);
      check_eq("rw_rvalid", rvalid, 1);
      check_eq("rw_regout", reg_out, model_flat());
      bready = 1'b1; rready = 1'b1;
      @(posedge aclk); #1;
      bready = 1'b0; rready = 1'b0;
      @(negedge aclk);
      check_eq("rw_clear", {bvalid, rvalid}, 2'b00);
      @(posedge aclk); #1;

      // Reset while B and R are both pending
      awaddr = 6'h00; wdata = 32'h12345678; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; araddr = 6'h04; arvalid = 1'b1;
      @(posedge aclk); #1;
      awvalid = 1'b0; wvalid = 1'b0; araddr = 6'h08;
      @(negedge aclk);
      check_eq("pre_rst_pending", {bvalid, rvalid}, 2'b11);
      aresetn = 1'b0;
      #1;
      check_all_zero("midrst");
      arvalid = 1'b0;
      for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;
      @(posedge aclk); #1;
      do_reset_release();
      do_write(6'h04, 32'h600DCAFE, 4'hF, 0, 0, 0);
      do_read(6'h04, 0, got);

      // Randomized traffic
      for (int t = 0; t < 80; t++) begin
         if ($urandom_range(0, 1) == 0)
            do_write(AW'($urandom_range(0, 23)), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(AW'($urandom_range(0, 23)), $urandom_range(0, 3), got);
      end
      check_eq("final_regout", reg_out, model_flat());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/bus_monitor_axil_regs.md
Name: bus_monitor_axil_regs

Overview:
AXI4-Lite slave register file for the bus monitor IP. It terminates the S00_AXI port driven by the master VIP / CPU interconnect. It holds NUM_REGS 32-bit read/write registers that the monitor core consumes as configuration. Write and read channels run independent handshake FSMs, with full backpressure support on B and R.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 is supported
ADDR_WIDTH, 6, AXI byte-address width
NUM_REGS, 4, number of implemented 32-bit registers at byte offsets 0x0, 0x4, …, 4*(NUM_REGS-1)

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  flat register contents to the monitor core; reg k is bits [32k+31:32k]

Behaviour:
- Reset (ARESETN low, asynchronous): all registers = 0; AWREADY = WREADY = ARREADY = 0; BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0. Ready signals rise on the first clock edge after reset deassertion.
- Reset asserted mid-transaction: any buffered AW/W/AR is discarded and all valids drop immediately. No partial write is committed.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle.
  - AWREADY = 1 iff no AW is buffered and BVALID = 0. WREADY = 1 iff no W is buffered and BVALID = 0.
  - A handshake captures addr or data+strb into a holding register.
- Write commit:
  - Occurs on the cycle both AW and W are held, or on the handshake cycle that completes the pair.
  - Index = AWADDR[ADDR_WIDTH-1:2]; AWADDR[1:0] is ignored.
  - If index < NUM_REGS: each byte with WSTRB[b] = 1 is updated, other bytes are kept; BRESP = OKAY (00).
  - Otherwise: no register changes; BRESP = SLVERR (10).
  - BVALID rises on the edge after commit and is held, with BRESP stable, until BREADY = 1. Both holding registers clear at commit.
- Minimum write latency: AW and W in the same cycle, then BVALID on the next edge, giving 1 cycle. Back-to-back writes with BREADY tied high sustain one write every 2 cycles.
- Read channel:
  - ARREADY = 1 iff RVALID = 0.
  - On an AR handshake, RDATA is loaded on the same edge: register[index] if index < NUM_REGS with RRESP = OKAY; otherwise 0 with RRESP = SLVERR. RVALID rises at that edge.
  - RDATA, RRESP and RVALID are held until RREADY = 1, then RVALID clears. Latency is 1 cycle.
- Read and write to the same register on the same edge: the read returns the pre-write value and the write still commits.
- reg_out updates on the edge after commit.
- Only one outstanding write and one outstanding read; no IDs.
- AWPROT and ARPROT are ignored.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back -> RDATA 0x1..0x4, all BRESP/RRESP = 00, reg_out = 0x00000004_00000003_00000002_00000001.
- W presented 3 cycles before AW (data 0xDEADBEEF to 0x4) -> WREADY drops after W handshake, no commit until AW, BVALID exactly 1 cycle after AW handshake, reg1 = 0xDEADBEEF.
- Write 0xAABBCCDD with WSTRB = 0101 over a reg holding 0x11223344 -> read returns 0x11BB33DD.
- Write to 0x10, then read from 0x10 -> BRESP = 10, RRESP = 10, RDATA = 0, all registers unchanged.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and data stable; AWREADY/WREADY/ARREADY stay 0 until release.
- Assert ARESETN low while BVALID = 1 and an AR is pending -> all outputs 0 within the same cycle, registers 0, and a fresh write after reset completes normally.
